psram_rd_checker: RTL and testbench
===================================

# psram_rd_checker

Read-data pattern checker on the `mem_clk` domain, directly downstream of the HyperRAM/PSRAM controller's calibrated read path. It consumes `rd_data_d[31:0]` qualified by `rd_data_valid_calib`, compares each word against a 32-bit LFSR expected sequence, and reports a pass/fail verdict, a saturating error count and the first mismatch. It is the on-chip counterpart to the logic-analyzer probes on the same signals, for board bring-up of the frame-buffer memory.

## Interface
- `DATA_W`, 32: read word width; fixed at 32 for this revision.
- `BURST_LEN`, 16: words returned per read command.
- `SEED`, 32'h0000_0001: LFSR start value; must be nonzero.
- `ERR_W`, 16: error counter width.
- `TIMEOUT_CYC`, 4096: maximum idle cycles between valid words while running.

Ports:
- `mem_clk`  in  1  sole clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  single-cycle pulse; arms a check pass.
- `num_bursts`  in  16  bursts to check; sampled when `start` is accepted.
- `rd_data_d`  in  32  read word from the controller.
- `rd_data_valid_calib`  in  1  qualifies `rd_data_d`.
- `busy`  out  1  high from accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at the end of a pass.
- `pass`  out  1  valid from `done` onward; 1 means no errors and no timeout.
- `timeout`  out  1  sticky until the next accepted `start`.
- `err_cnt`  out  ERR_W  mismatch count; saturates at all-ones.
- `first_err_idx`  out  32  word index of the first mismatch.
- `first_err_data`  out  32  received word at the first mismatch.
- `first_err_exp`  out  32  expected word at the first mismatch.
- `stray`  out  1  sticky; a valid word arrived while not running.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE → RUN on `start`.
  - Load LFSR with `SEED`.
  - Load `total = num_bursts * BURST_LEN`, computed 32-bit, no overflow.
  - Clear `err_cnt`, `word_idx`, `timeout`, the first-error registers and the internal `err_seen`.
  - If `num_bursts == 0`, go directly to DONE.
- RUN, on each valid word:
  - Compare `rd_data_d` with the LFSR state.
  - Advance the LFSR and increment `word_idx`.
  - On mismatch: increment `err_cnt`, saturating. If `err_seen == 0`, capture idx/data/exp and set `err_seen`.
- RUN exit conditions:
  - RUN → DONE when the valid word being accepted has `word_idx == total-1`.
  - RUN → DONE when the idle counter reaches `TIMEOUT_CYC` with no valid word; this sets `timeout`.
  - The idle counter clears on every valid word.
- DONE: `done = 1` and `pass = (err_cnt == 0) && !timeout`, then DONE → IDLE unconditionally.
- LFSR is Galois, right-shifting, with polynomial mask `LFSR_POLY = 32'h8020_0003`: `next = (s >> 1) ^ (s[0] ? LFSR_POLY : 0)`.
- `start` while `busy` is ignored.
- A valid word in the same cycle as `start` in IDLE is not checked; it sets `stray`.
- Any valid word in IDLE or DONE sets `stray`. `stray` clears only on reset.
- Reset mid-pass aborts with no `done`.
- All outputs reset to 0. `pass` resets to 0 and holds its value until the next accepted `start`, which clears it.

## Timing
- Compare is registered. A word valid at edge t updates `err_cnt` and the first-error registers at t+1.
- For the last word at t: state is DONE, `done` = 1 and `err_cnt` is final, all at t+1. `busy` drops at t+2.
- Back-to-back valid words are accepted every cycle; there is no backpressure.
- `start` accepted at t: `busy` = 1 at t+1, and the first word is checked from t+1.
- `num_bursts == 0`: `done` at t+2, `pass` = 1.
- Timeout: `done` fires `TIMEOUT_CYC`+1 cycles after the last valid word, or after entering RUN if no word arrived.

## Structure
- Package `psram_chk_pkg` holds:
  - the state enum,
  - `LFSR_POLY`,
  - function `lfsr_next`.
- Sub-module `psram_lfsr32` has `load`, `seed`, `adv` and `q`. The same generator is reused by the write-side pattern source so both sides share one sequence.

## Test plan
- `SEED` = 1, `num_bursts` = 1, 16 correct words back-to-back. Words 0–2 are 32'h1, 32'h8020_0003, 32'hC030_0002. Required: `done` the cycle after word 15, `pass` = 1, `err_cnt` = 0.
- Same pass with word 5 XOR 32'h1 and word 9 corrupted. Required: `err_cnt` = 2, `first_err_idx` = 5, `first_err_data` = `first_err_exp` ^ 1, `pass` = 0.
- `num_bursts` = 2 with gaps of 0–7 idle cycles between words. Required: `pass` = 1 after exactly 32 valid words.
- `TIMEOUT_CYC` = 16, stop after 10 words. Required: `timeout` = 1, `done` 17 cycles after word 9, `pass` = 0.
- `start` with `num_bursts` = 0. Required: `done` at t+2, `pass` = 1. Valid word in IDLE: `stray` = 1.
- Reset asserted mid-RUN. Required: all outputs 0 next cycle, no `done`. A following pass behaves as in the first scenario.

Source files
------------

// File: rtl/psram_chk_pkg.sv
// Shared types and pattern generator math for the PSRAM read-data checker
// and its write-side pattern source.
package psram_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } chk_state_t;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // Galois, right-shifting: feedback taps applied when the bit shifted out is 1.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0000_0000);
  endfunction

endpackage

// File: rtl/psram_lfsr32.sv
// 32-bit pattern LFSR shared by the read checker and the write pattern source,
// so both sides walk the same sequence.
module psram_lfsr32
  import psram_chk_pkg::*;
(
  input  logic        mem_clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        adv,
  output logic [31:0] q
);

  always_ff @(posedge mem_clk) begin
    if (!rst_n) begin
      q <= 32'h0000_0000;
    end else if (load) begin
      q <= seed;
    end else if (adv) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/psram_rd_checker.sv
// Read-data pattern checker for HyperRAM/PSRAM bring-up: compares calibrated
// read words against the LFSR sequence and reports verdict and first mismatch.
//
// state | meaning
// IDLE  | waiting for start; any valid word is stray
// RUN   | checking words, idle timer armed
// DONE  | one-cycle verdict, done pulse
module psram_rd_checker
  import psram_chk_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int          BURST_LEN   = 16,
  parameter logic [31:0] SEED        = 32'h0000_0001,
  parameter int          ERR_W       = 16,
  parameter int          TIMEOUT_CYC = 4096
) (
  input  logic              mem_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       num_bursts,
  input  logic [DATA_W-1:0] rd_data_d,
  input  logic              rd_data_valid_calib,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [31:0]       first_err_idx,
  output logic [DATA_W-1:0] first_err_data,
  output logic [DATA_W-1:0] first_err_exp,
  output logic              stray
);

  localparam int             TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYC);

  chk_state_t        state_q, state_d;
  logic [31:0]       total_q;
  logic [31:0]       word_idx_q;
  logic [TO_W-1:0]   idle_q;
  logic              err_seen_q;
  logic              pass_q;
  logic [31:0]       lfsr_q;

  logic start_acc, total_zero, accept, last_word, mismatch, to_hit, pass_now;

  psram_lfsr32 u_lfsr (
    .mem_clk (mem_clk),
    .rst_n   (rst_n),
    .load    (start_acc),
    .seed    (SEED),
    .adv     (accept),
    .q       (lfsr_q)
  );

  // A zero-burst pass still spends one cycle in RUN so done lands two cycles
  // after start, same as any other pass shape seen by software.
  always_comb begin
    start_acc  = (state_q == ST_IDLE) && start;
    total_zero = (total_q == 32'h0000_0000);
    accept     = (state_q == ST_RUN) && rd_data_valid_calib && !total_zero;
    last_word  = accept && (word_idx_q == total_q - 32'd1);
    mismatch   = accept && (rd_data_d != lfsr_q);
    to_hit     = (state_q == ST_RUN) && !rd_data_valid_calib && !total_zero
                 && (idle_q == '0);
    pass_now   = (err_cnt == '0) && !timeout;

    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (total_zero || last_word || to_hit) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge mem_clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      total_q        <= '0;
      word_idx_q     <= '0;
      idle_q         <= '0;
      err_seen_q     <= 1'b0;
      err_cnt        <= '0;
      first_err_idx  <= '0;
      first_err_data <= '0;
      first_err_exp  <= '0;
      timeout        <= 1'b0;
      stray          <= 1'b0;
      pass_q         <= 1'b0;
    end else begin
      state_q <= state_d;

      if (rd_data_valid_calib && (state_q != ST_RUN || total_zero)) begin
        stray <= 1'b1;
      end

      if (start_acc) begin
        total_q        <= 32'(num_bursts) * 32'(BURST_LEN);
        word_idx_q     <= '0;
        idle_q         <= TO_LOAD;
        err_seen_q     <= 1'b0;
        err_cnt        <= '0;
        first_err_idx  <= '0;
        first_err_data <= '0;
        first_err_exp  <= '0;
        timeout        <= 1'b0;
        pass_q         <= 1'b0;
      end

      if (accept) begin
        word_idx_q <= word_idx_q + 32'd1;
        idle_q     <= TO_LOAD;
      end else if (state_q == ST_RUN && idle_q != '0) begin
        idle_q <= idle_q - TO_W'(1);
      end

      if (mismatch) begin
        if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
        if (!err_seen_q) begin
          err_seen_q     <= 1'b1;
          first_err_idx  <= word_idx_q;
          first_err_data <= rd_data_d;
          first_err_exp  <= lfsr_q;
        end
      end

      if (to_hit) timeout <= 1'b1;

      if (state_q == ST_DONE) pass_q <= pass_now;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign pass = (state_q == ST_DONE) ? pass_now : pass_q;

endmodule

// File: tb/tb_psram_rd_checker.sv
// Directed bench for psram_rd_checker: table of pass shapes plus hand-written
// sequences for zero bursts, stray words and reset mid-pass.
module tb_psram_rd_checker;

  logic        mem_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_bursts = 16'd0;
  logic [31:0] rd_data_d = 32'd0;
  logic        rd_data_valid_calib = 1'b0;
  logic        busy, done, pass, timeout, stray;
  logic [15:0] err_cnt;
  logic [31:0] first_err_idx, first_err_data, first_err_exp;

  int checks = 0;
  int failures = 0;

  psram_rd_checker #(
    .DATA_W(32), .BURST_LEN(16), .SEED(32'h0000_0001), .ERR_W(16), .TIMEOUT_CYC(16)
  ) dut (
    .mem_clk(mem_clk), .rst_n(rst_n), .start(start), .num_bursts(num_bursts),
    .rd_data_d(rd_data_d), .rd_data_valid_calib(rd_data_valid_calib),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_cnt(err_cnt),
    .first_err_idx(first_err_idx), .first_err_data(first_err_data),
    .first_err_exp(first_err_exp), .stray(stray)
  );

  always #5 mem_clk = ~mem_clk;

  typedef struct {
    int          nb;
    bit          gaps;
    int          stop_after;
    int          err_a;
    int          err_b;
    int          exp_err;
    bit          exp_pass;
    bit          exp_to;
    int          exp_first_idx;
    logic [31:0] exp_first_exp;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [31:0] model_next(input logic [31:0] s);
    logic [31:0] n;
    n = {1'b0, s[31:1]};
    if (s[0]) n = n ^ 32'h8020_0003;
    return n;
  endfunction

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string name, input bit start_with_valid);
    int nwords;
    int lat;
    bit early;
    logic [31:0] exp;
    logic [31:0] corr;
    nwords = (v.stop_after > 0) ? v.stop_after : v.nb * 16;
    early = 1'b0;
    start = 1'b1;
    num_bursts = 16'(v.nb);
    if (start_with_valid) begin
      rd_data_valid_calib = 1'b1;
      rd_data_d = 32'hDEAD_BEEF;
    end
    tick();
    start = 1'b0;
    rd_data_valid_calib = 1'b0;
    chk({name, " busy_after_start"}, 32'(busy), 32'd1);
    exp = 32'h0000_0001;
    for (int i = 0; i < nwords; i++) begin
      if (v.gaps) begin
        for (int g = 0; g < (i % 8); g++) begin
          tick();
          if (done) early = 1'b1;
        end
      end
      corr = 32'd0;
      if (i == v.err_a) corr = 32'h0000_0001;
      if (i == v.err_b) corr = 32'hFFFF_0000;
      rd_data_valid_calib = 1'b1;
      rd_data_d = exp ^ corr;
      tick();
      rd_data_valid_calib = 1'b0;
      if (i != nwords - 1 && done) early = 1'b1;
      exp = model_next(exp);
    end
    chk({name, " no_early_done"}, 32'(early), 32'd0);
    lat = 0;
    while (!done && lat < 200) begin
      tick();
      lat++;
    end
    chk({name, " done_latency"}, 32'(lat), 32'(v.exp_lat));
    chk({name, " err_cnt"}, 32'(err_cnt), 32'(v.exp_err));
    chk({name, " pass"}, 32'(pass), 32'(v.exp_pass));
    chk({name, " timeout"}, 32'(timeout), 32'(v.exp_to));
    if (v.exp_err > 0) begin
      chk({name, " first_err_idx"}, first_err_idx, 32'(v.exp_first_idx));
      chk({name, " first_err_exp"}, first_err_exp, v.exp_first_exp);
      chk({name, " first_err_data"}, first_err_data, v.exp_first_exp ^ 32'h1);
    end
    tick();
    chk({name, " busy_dropped"}, 32'(busy), 32'd0);
    chk({name, " done_one_cycle"}, 32'(done), 32'd0);
    chk({name, " pass_held"}, 32'(pass), 32'(v.exp_pass));
  endtask

  initial begin
    int dcount;
    //          nb gaps stop ea  eb  err pass to  fidx exp_first      lat
    vecs[0] = '{1, 0,   0,  -1, -1, 0,  1,   0,  0,   32'h0,         0};
    vecs[1] = '{1, 0,   0,   5,  9, 2,  0,   0,  5,   32'hD836_0002, 0};
    vecs[2] = '{2, 1,   0,  -1, -1, 0,  1,   0,  0,   32'h0,         0};
    vecs[3] = '{1, 0,   10, -1, -1, 0,  0,   1,  0,   32'h0,         17};
    vecs[4] = '{1, 0,   0,   0, -1, 1,  0,   0,  0,   32'h0000_0001, 0};
    vecs[5] = '{2, 0,   0,  31, -1, 1,  0,   0,  31,  32'h0,         0};
    // word 31 of the sequence, derived by the bench model below
    begin
      logic [31:0] s;
      s = 32'h1;
      for (int k = 0; k < 31; k++) s = model_next(s);
      vecs[5].exp_first_exp = s;
    end

    repeat (3) tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_pass", 32'(pass), 32'd0);
    chk("reset_err_cnt", 32'(err_cnt), 32'd0);
    chk("reset_stray", 32'(stray), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      run_vec(vecs[v], $sformatf("vec%0d", v), 1'b0);
      tick();
    end
    chk("no_stray_after_table", 32'(stray), 32'd0);

    // zero-burst pass: done two cycles after start
    start = 1'b1;
    num_bursts = 16'd0;
    tick();
    start = 1'b0;
    chk("zero_busy_t1", 32'(busy), 32'd1);
    chk("zero_done_t1", 32'(done), 32'd0);
    tick();
    chk("zero_done_t2", 32'(done), 32'd1);
    chk("zero_pass", 32'(pass), 32'd1);
    tick();
    chk("zero_busy_drop", 32'(busy), 32'd0);

    // valid word in IDLE
    rd_data_valid_calib = 1'b1;
    rd_data_d = 32'h1234_5678;
    tick();
    rd_data_valid_calib = 1'b0;
    chk("stray_idle", 32'(stray), 32'd1);
    tick();
    // word alongside start is not checked
    run_vec(vecs[0], "start_with_valid", 1'b1);
    tick();

    // reset mid-RUN with an error already recorded
    start = 1'b1;
    num_bursts = 16'd1;
    tick();
    start = 1'b0;
    begin
      logic [31:0] s;
      s = 32'h1;
      for (int i = 0; i < 6; i++) begin
        rd_data_valid_calib = 1'b1;
        rd_data_d = (i == 2) ? (s ^ 32'h1) : s;
        tick();
        s = model_next(s);
      end
      rd_data_valid_calib = 1'b0;
    end
    chk("mid_err_before_reset", 32'(err_cnt), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_first_idx", first_err_idx, 32'd0);
    chk("rst_first_data", first_err_data, 32'd0);
    chk("rst_first_exp", first_err_exp, 32'd0);
    chk("rst_stray", 32'(stray), 32'd0);
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) dcount++;
    end
    chk("rst_no_done", 32'(dcount), 32'd0);
    run_vec(vecs[0], "after_reset", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
